// File: rtl/road_density_sensor.sv
// Four-road vehicle occupancy counter with saturating counts, sticky error flags and
// registered density codes. Define SENSOR_FILTER_EN to compile in the per-road code filter.
module road_density_sensor #(
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned LESS_TH     = 1,
    parameter int unsigned MORE_TH     = 8,
    parameter int unsigned FULL_TH     = 16,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       A4,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    input  logic       D4,
    output logic [2:0] S1,
    output logic [2:0] S2,
    output logic [2:0] S3,
    output logic [2:0] S4,
    output logic [3:0] ERR
);

    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LessTh  = CNT_W'(LESS_TH);
    localparam logic [CNT_W-1:0] MoreTh  = CNT_W'(MORE_TH);
    localparam logic [CNT_W-1:0] FullTh  = CNT_W'(FULL_TH);

    localparam logic [2:0] CodeEmpty = 3'b000;
    localparam logic [2:0] CodeLess  = 3'b001;
    localparam logic [2:0] CodeMore  = 3'b011;
    localparam logic [2:0] CodeFull  = 3'b111;

    // Parameter sanity, caught at elaboration rather than as silent misbehaviour.
    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("HOLD_CYCLES must lie in 2..15");
    end
    if (LESS_TH > MORE_TH || MORE_TH > FULL_TH || FULL_TH > (1 << CNT_W) - 1) begin : g_bad_th
        $error("thresholds must satisfy LESS_TH <= MORE_TH <= FULL_TH <= 2**CNT_W-1");
    end

    logic [3:0] arr;
    logic [3:0] dep;
    logic [2:0] s_road [4];

    assign arr = {A4, A3, A2, A1};
    assign dep = {D4, D3, D2, D1};

    assign S1 = s_road[0];
    assign S2 = s_road[1];
    assign S3 = s_road[2];
    assign S4 = s_road[3];

    for (genvar r = 0; r < 4; r++) begin : g_road
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             err_q;
        logic             err_d;
        logic             inc;
        logic             dec;
        logic [2:0]       cand;
        logic [2:0]       s_q;
        logic [2:0]       s_d;

        // Simultaneous arrival and departure cancel out.
        assign inc = arr[r] & ~dep[r];
        assign dec = dep[r] & ~arr[r];

        always_comb begin
            cnt_d = cnt_q;
            err_d = err_q;
            if (inc) begin
                if (cnt_q == CntMax) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (dec) begin
                if (cnt_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        // Candidate code comes from the registered count, hence one edge behind it.
        always_comb begin
            if (cnt_q < LessTh) begin
                cand = CodeEmpty;
            end else if (cnt_q < MoreTh) begin
                cand = CodeLess;
            end else if (cnt_q < FullTh) begin
                cand = CodeMore;
            end else begin
                cand = CodeFull;
            end
        end

`ifdef SENSOR_FILTER_EN
        localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

        logic [2:0] pend_q;
        logic [2:0] pend_d;
        logic [3:0] stab_q;
        logic [3:0] stab_d;

        // A new code must stay put for HOLD_CYCLES edges before it reaches the output.
        always_comb begin
            s_d    = s_q;
            pend_d = pend_q;
            stab_d = stab_q;
            if (cand == s_q) begin
                stab_d = '0;
            end else if (cand != pend_q) begin
                pend_d = cand;
                stab_d = 4'd1;
            end else if (stab_q == HoldLast) begin
                s_d    = cand;
                stab_d = '0;
            end else begin
                stab_d = stab_q + 4'd1;
            end
        end

        always_ff @(posedge clock) begin
            if (clear) begin
                pend_q <= CodeEmpty;
                stab_q <= '0;
            end else begin
                pend_q <= pend_d;
                stab_q <= stab_d;
            end
        end
`else
        always_comb begin
            s_d = cand;
        end
`endif

        always_ff @(posedge clock) begin
            if (clear) begin
                cnt_q <= '0;
                err_q <= 1'b0;
                s_q   <= CodeEmpty;
            end else begin
                cnt_q <= cnt_d;
                err_q <= err_d;
                s_q   <= s_d;
            end
        end

        assign s_road[r] = s_q;
        assign ERR[r]    = err_q;
    end

endmodule

// File: tb/tb_road_density_sensor.sv
// Scoreboard bench for road_density_sensor; follows SENSOR_FILTER_EN like the design does.
module tb_road_density_sensor;

    localparam int CntMax = 63;
    localparam int Hold   = 4;

    logic       clock = 1'b0;
    logic       clear;
    logic       A1, A2, A3, A4;
    logic       D1, D2, D3, D4;
    logic [2:0] S1, S2, S3, S4;
    logic [3:0] ERR;

    int checks = 0;
    int errors = 0;

    // Expected outputs packed as {S4, S3, S2, S1, ERR}.
    logic [15:0] exp_q [$];

    int         m_cnt  [4];
    logic [2:0] m_s    [4];
    logic [2:0] m_pend [4];
    int         m_stab [4];
    logic [3:0] m_err;

    road_density_sensor dut (
        .clock (clock),
        .clear (clear),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .A4    (A4),
        .D1    (D1),
        .D2    (D2),
        .D3    (D3),
        .D4    (D4),
        .S1    (S1),
        .S2    (S2),
        .S3    (S3),
        .S4    (S4),
        .ERR   (ERR)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] code_of(input int c);
        if (c < 1) return 3'b000;
        if (c < 8) return 3'b001;
        if (c < 16) return 3'b011;
        return 3'b111;
    endfunction

    task automatic model_step(input logic [3:0] a, input logic [3:0] d, input logic clr);
        logic [2:0] c;
        if (clr) begin
            for (int r = 0; r < 4; r++) begin
                m_cnt[r]  = 0;
                m_s[r]    = 3'b000;
                m_pend[r] = 3'b000;
                m_stab[r] = 0;
            end
            m_err = 4'b0000;
        end else begin
            for (int r = 0; r < 4; r++) begin
                c = code_of(m_cnt[r]);
`ifdef SENSOR_FILTER_EN
                if (c == m_s[r]) begin
                    m_stab[r] = 0;
                end else if (c != m_pend[r]) begin
                    m_pend[r] = c;
                    m_stab[r] = 1;
                end else if (m_stab[r] == Hold - 1) begin
                    m_s[r]    = c;
                    m_stab[r] = 0;
                end else begin
                    m_stab[r] = m_stab[r] + 1;
                end
`else
                m_s[r] = c;
`endif
                if (a[r] && !d[r]) begin
                    if (m_cnt[r] == CntMax) m_err[r] = 1'b1;
                    else m_cnt[r] = m_cnt[r] + 1;
                end else if (d[r] && !a[r]) begin
                    if (m_cnt[r] == 0) m_err[r] = 1'b1;
                    else m_cnt[r] = m_cnt[r] - 1;
                end
            end
        end
    endtask

    // One clock: apply inputs, predict, then compare after the edge.
    task automatic drive(input logic [3:0] a, input logic [3:0] d, input logic clr);
        logic [15:0] e;
        {A4, A3, A2, A1} = a;
        {D4, D3, D2, D1} = d;
        clear = clr;
        model_step(a, d, clr);
        exp_q.push_back({m_s[3], m_s[2], m_s[1], m_s[0], m_err});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check_eq("S1", 32'(S1), 32'(e[6:4]));
        check_eq("S2", 32'(S2), 32'(e[9:7]));
        check_eq("S3", 32'(S3), 32'(e[12:10]));
        check_eq("S4", 32'(S4), 32'(e[15:13]));
        check_eq("ERR", 32'(ERR), 32'(e[3:0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 4'b0000, 1'b0);
    endtask

    initial begin
        {A4, A3, A2, A1} = '0;
        {D4, D3, D2, D1} = '0;
        clear = 1'b1;
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b1111, 4'b0000, 1'b1);
        check_eq("reset_S1", 32'(S1), 32'h0);
        check_eq("reset_S4", 32'(S4), 32'h0);
        check_eq("reset_ERR", 32'(ERR), 32'h0);

        // Eight single-cycle arrivals on road 1.
        drive(4'b0001, 4'b0000, 1'b0);
`ifndef SENSOR_FILTER_EN
        check_eq("s1_lag_first", 32'(S1), 32'h0);
        idle(1);
        check_eq("s1_less_next", 32'(S1), 32'h1);
`else
        idle(1);
`endif
        for (int i = 0; i < 7; i++) begin
            drive(4'b0001, 4'b0000, 1'b0);
            idle(1);
        end
        idle(6);
        check_eq("s1_more", 32'(S1), 32'h3);
        check_eq("s2_idle", 32'(S2), 32'h0);

        // Road 2: count 3, then simultaneous A2/D2 holds it.
        for (int i = 0; i < 3; i++) drive(4'b0010, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) drive(4'b0010, 4'b0010, 1'b0);
        idle(6);
        check_eq("s2_hold", 32'(S2), 32'h1);
        check_eq("err_none", 32'(ERR), 32'h0);

        // Road 3: departure at zero sets a sticky error.
        drive(4'b0000, 4'b0100, 1'b0);
        check_eq("err_underflow", 32'(ERR), 32'h4);
        for (int i = 0; i < 4; i++) drive(4'b0100, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0100, 1'b0);
        idle(6);
        check_eq("err_sticky", 32'(ERR), 32'h4);

        // Road 4: hold arrivals long enough to saturate.
        for (int i = 0; i < 70; i++) drive(4'b1000, 4'b0000, 1'b0);
        idle(6);
        check_eq("s4_full", 32'(S4), 32'h7);
        check_eq("err_overflow", 32'(ERR), 32'hC);

        // Road 1 oscillating around the MORE threshold.
        drive(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 7; i++) drive(4'b0001, 4'b0000, 1'b0);
        idle(6);
        check_eq("s1_at7", 32'(S1), 32'h1);
        for (int i = 0; i < 10; i++) begin
            drive(4'b0001, 4'b0000, 1'b0);
            drive(4'b0000, 4'b0001, 1'b0);
`ifdef SENSOR_FILTER_EN
            check_eq("s1_flicker", 32'(S1), 32'h1);
`endif
        end
        drive(4'b0001, 4'b0000, 1'b0);
`ifdef SENSOR_FILTER_EN
        for (int k = 1; k <= Hold; k++) begin
            idle(1);
            check_eq("s1_filtered", 32'(S1), (k == Hold) ? 32'h3 : 32'h1);
        end
`else
        idle(1);
        check_eq("s1_unfiltered", 32'(S1), 32'h3);
`endif

        // Clear at count 20 with an update likely pending.
        drive(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) drive(4'b0001, 4'b0000, 1'b0);
        drive(4'b0001, 4'b0000, 1'b1);
        check_eq("clr_S1", 32'(S1), 32'h0);
        check_eq("clr_ERR", 32'(ERR), 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check_eq("clr_no_stale", 32'({S4, S3, S2, S1}), 32'h0);
        end

        // Random traffic: first biased to fill, then biased to drain.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] a;
            logic [3:0] d;
            a = 4'($urandom);
            d = 4'($urandom) & 4'($urandom);
            if (i >= 150) begin
                logic [3:0] t;
                t = a;
                a = d;
                d = t;
            end
            drive(a, d, ($urandom_range(0, 79) == 0));
        end
        idle(Hold + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
